// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
// Default geometry: 8-bit operands in 4-bit lookahead groups.
package cla_pkg;

   localparam int unsigned CLA_WIDTH = 8;
   localparam int unsigned CLA_GROUP = 4;
   localparam int unsigned NGRP      = CLA_WIDTH / CLA_GROUP;

   typedef struct packed {
      logic [CLA_WIDTH-1:0] g;
      logic [CLA_WIDTH-1:0] p;
      logic [CLA_WIDTH-1:0] t;
      logic                 cin;
   } s1_t;

   // Returns {G, P} for one group; G is the group carry-out assuming zero carry-in.
   function automatic logic [1:0] grp_gp(input logic [CLA_GROUP-1:0] g,
                                         input logic [CLA_GROUP-1:0] p);
      logic gg;
      logic pp;
      gg = 1'b0;
      pp = 1'b1;
      for (int unsigned i = 0; i < CLA_GROUP; i++) begin
         gg = g[i] | (p[i] & gg);
         pp = pp & p[i];
      end
      return {gg, pp};
   endfunction

endpackage

// File: rtl/cla_group_unit.sv
// One GROUP-bit lookahead block: group generate/propagate plus the carry
// into each bit of the group given the group carry-in.
module cla_group_unit
   import cla_pkg::*;
(
   input  logic [CLA_GROUP-1:0] g,
   input  logic [CLA_GROUP-1:0] p,
   input  logic                 c_in,
   output logic                 grp_g,
   output logic                 grp_p,
   output logic [CLA_GROUP-1:0] carry
);

   logic c_run;

   always_comb begin
      {grp_g, grp_p} = grp_gp(g, p);
      c_run = c_in;
      carry = '0;
      for (int unsigned i = 0; i < CLA_GROUP; i++) begin
         carry[i] = c_run;
         c_run    = g[i] | (p[i] & c_run);
      end
   end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined block carry-lookahead adder with valid/ready on both sides.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = CLA_WIDTH,
   parameter int unsigned GROUP = CLA_GROUP
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   input  logic                     cin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         sum,
   output logic                     cout,
   output logic [WIDTH/GROUP-1:0]   grp_g,
   output logic [WIDTH/GROUP-1:0]   grp_p
`ifdef CLA_OVF_EN
   ,
   output logic                     ovf
`endif
);

   localparam int unsigned NG = WIDTH / GROUP;

   if (WIDTH % GROUP != 0) begin : g_chk_mult
      $fatal(1, "cla_pipe_adder: WIDTH (%0d) must be a multiple of GROUP (%0d)", WIDTH, GROUP);
   end
   // Stage-1 struct and group function are sized by the package geometry.
   if (WIDTH != CLA_WIDTH || GROUP != CLA_GROUP || NG != NGRP) begin : g_chk_pkg
      $fatal(1, "cla_pipe_adder: WIDTH/GROUP must match cla_pkg geometry");
   end

   s1_t  s1_q;
   logic s1_valid;
   logic s2_valid;
   logic s1_load;
   logic s2_adv;

   assign s2_adv    = s1_valid && (!s2_valid || out_ready);
   assign in_ready  = !s1_valid || s2_adv;
   assign s1_load   = in_valid && in_ready;
   assign out_valid = s2_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         s1_q     <= '{g: a & b, p: a | b, t: a ^ b, cin: cin};
      end else if (s2_adv) begin
         s1_valid <= 1'b0;
      end
   end

   logic [NG-1:0]    grp_gen;
   logic [NG-1:0]    grp_prop;
   logic [NG:0]      grp_c;
   logic [GROUP-1:0] unit_c [NG];
   logic [WIDTH:0]   c;

   for (genvar k = 0; k < NG; k++) begin : g_grp
      cla_group_unit u_grp (
         .g     (s1_q.g[k*GROUP +: GROUP]),
         .p     (s1_q.p[k*GROUP +: GROUP]),
         .c_in  (grp_c[k]),
         .grp_g (grp_gen[k]),
         .grp_p (grp_prop[k]),
         .carry (unit_c[k])
      );
   end

   // Group carries come only from G/P, so the per-bit carries in each unit never loop back.
   always_comb begin
      grp_c    = '0;
      grp_c[0] = s1_q.cin;
      for (int unsigned k = 0; k < NG; k++) begin
         grp_c[k+1] = grp_gen[k] | (grp_prop[k] & grp_c[k]);
      end
   end

   always_comb begin
      c        = '0;
      c[WIDTH] = grp_c[NG];
      for (int unsigned k = 0; k < NG; k++) begin
         for (int unsigned i = 0; i < GROUP; i++) begin
            c[k*GROUP + i] = unit_c[k][i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         grp_g    <= '0;
         grp_p    <= '0;
`ifdef CLA_OVF_EN
         ovf      <= 1'b0;
`endif
      end else if (s2_adv) begin
         s2_valid <= 1'b1;
         sum      <= s1_q.t ^ c[WIDTH-1:0];
         cout     <= c[WIDTH];
         grp_g    <= grp_gen;
         grp_p    <= grp_prop;
`ifdef CLA_OVF_EN
         ovf      <= c[WIDTH-1] ^ c[WIDTH];
`endif
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: expected results from plain integer arithmetic.
// Define CLA_OVF_EN to also check the ovf output.
module tb_cla_pipe_adder;

   localparam int unsigned W = 8;
   localparam int unsigned G = 4;
   localparam int unsigned N = W / G;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic [N-1:0] grp_g;
   logic [N-1:0] grp_p;
`ifdef CLA_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;
   int n_out  = 0;
   bit rand_rdy = 1'b0;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic [N-1:0] gg;
      logic [N-1:0] gp;
      logic         ovf;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .grp_g     (grp_g),
      .grp_p     (grp_p)
`ifdef CLA_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      exp_t        e;
      int unsigned tot, xs, ys, msk;
      int          s;
      tot    = int'(x) + int'(y) + int'(ci);
      e.sum  = tot[W-1:0];
      e.cout = tot[W];
      msk    = (1 << G) - 1;
      for (int unsigned k = 0; k < N; k++) begin
         xs      = (int'(x) >> (k * G)) & msk;
         ys      = (int'(y) >> (k * G)) & msk;
         e.gg[k] = (xs + ys) > msk;
         e.gp[k] = (xs | ys) == msk;
      end
      s     = int'($signed(x)) + int'($signed(y)) + int'(ci);
      e.ovf = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) sb.push_back(model(a, b, cin));
   end

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got sum %0h expected no output at %0t", sum, $time);
         end else begin
            chk("sum", 32'(sum), 32'(sb[0].sum));
            chk("cout", 32'(cout), 32'(sb[0].cout));
            chk("grp_g", 32'(grp_g), 32'(sb[0].gg));
            chk("grp_p", 32'(grp_p), 32'(sb[0].gp));
`ifdef CLA_OVF_EN
            chk("ovf", 32'(ovf), 32'(sb[0].ovf));
`endif
            if (out_ready) begin
               void'(sb.pop_front());
               n_out++;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Called just after a rising edge; returns just after the accepting edge with in_valid still high.
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, output int waited);
      in_valid = 1'b1;
      a = x;
      b = y;
      cin = ci;
      waited = 0;
      while (1) begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 200) break;
      end
      if (waited > 200) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 500; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      @(posedge clk);
      #1;
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      int n0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_grp", 32'({grp_g, grp_p}), 32'd0);
`ifdef CLA_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      // Single op and latency
      send(8'h0F, 8'h01, 1'b0, w);
      in_valid = 1'b0;
      chk("lat_c1_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_c2_valid", 32'(out_valid), 32'd1);
      chk("t1_sum", 32'(sum), 32'h10);
      chk("t1_cout", 32'(cout), 32'd0);
      chk("t1_grp_g", 32'(grp_g), 32'b01);
      chk("t1_grp_p", 32'(grp_p), 32'b01);
      drain();

      // Full propagate
      send(8'hFF, 8'h00, 1'b1, w);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("t2a_sum", 32'(sum), 32'h00);
      chk("t2a_cout", 32'(cout), 32'd1);
      chk("t2a_grp", 32'({grp_g, grp_p}), 32'b0011);
      send(8'hFF, 8'hFF, 1'b1, w);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("t2b_sum", 32'(sum), 32'hFF);
      chk("t2b_cout", 32'(cout), 32'd1);
      drain();

      // Back-to-back
      n0 = n_out;
      for (int i = 0; i < 4; i++) begin
         send(W'($urandom), W'($urandom), 1'($urandom), w);
         chk("b2b_ready_wait", 32'(w), 32'd0);
      end
      in_valid = 1'b0;
      drain();
      chk("b2b_count", 32'(n_out - n0), 32'd4);

      // Backpressure
      n0 = n_out;
      out_ready = 1'b0;
      send(8'h12, 8'h34, 1'b0, w);
      send(8'hA5, 8'h5A, 1'b1, w);
      chk("bp_second_wait", 32'(w), 32'd0);
      a = 8'h77;
      b = 8'h99;
      cin = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();
      chk("bp_count", 32'(n_out - n0), 32'd3);

      // Reset with both stages full
      out_ready = 1'b0;
      send(8'h01, 8'h02, 1'b0, w);
      send(8'h03, 8'h04, 1'b0, w);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_sum", 32'(sum), 32'd0);
      chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(8'h20, 8'h22, 1'b1, w);
      in_valid = 1'b0;
      chk("rst_lat_c1", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_lat_c2", 32'(out_valid), 32'd1);
      chk("rst_first_sum", 32'(sum), 32'h43);
      drain();

      // Signed overflow corners
      send(8'h7F, 8'h01, 1'b0, w);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
`ifdef CLA_OVF_EN
      chk("ovf_7f_01", 32'(ovf), 32'd1);
`endif
      chk("sum_7f_01", 32'(sum), 32'h80);
      send(8'h80, 8'hFF, 1'b0, w);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
`ifdef CLA_OVF_EN
      chk("ovf_80_ff", 32'(ovf), 32'd1);
`endif
      chk("cout_80_ff", 32'(cout), 32'd1);
      send(8'h01, 8'h01, 1'b0, w);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
`ifdef CLA_OVF_EN
      chk("ovf_01_01", 32'(ovf), 32'd0);
`endif
      chk("sum_01_01", 32'(sum), 32'h02);
      drain();

      // Random traffic with random backpressure
      n0 = n_out;
      rand_rdy = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         send(W'($urandom), W'($urandom), 1'($urandom), w);
      end
      in_valid = 1'b0;
      rand_rdy = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();
      chk("rand_count", 32'(n_out - n0), 32'd10000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
